exec_issue_queue: RTL and testbench
===================================

# exec_issue_queue

Parametrised issue queue that replaces the plain per-unit execution FIFO between the dispatch stage and each execution unit (integer, load/store, multiply, divide). Each entry holds an opaque instruction payload, the destination tag and two source operands; pending operands snoop the CDB and capture data when their tag is broadcast. Entries are kept in age order and issue only when both operands are ready, so a unit never receives an instruction with unresolved sources. The queue supports depth/width/tag parametrisation and a compile-time in-order or out-of-order issue policy.

## Interface
- DEPTH, 4, number of entries (≥2)
- PAYLOAD_W, 64, opaque payload width (opcode, func3/func7, immediate, branch address, ...)
- TAG_W, 6, tag width (matches tag_fifo)
- i_clk  in  1  clock, all state on rising edge
- i_rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous flush of all entries
- dispatch_en  in  1  write one entry this cycle
- dispatch_payload  in  PAYLOAD_W  payload
- dispatch_rd_tag  in  TAG_W  destination tag
- dispatch_rs1_pending / dispatch_rs2_pending  in  1  operand waiting on tag (RST valid bit)
- dispatch_rs1_tag / dispatch_rs2_tag  in  TAG_W  producer tag
- dispatch_rs1_data / dispatch_rs2_data  in  32  operand value when not pending
- cdb_valid  in  1  CDB broadcast valid
- cdb_tag  in  TAG_W  broadcast tag
- cdb_data  in  32  broadcast value
- issue_ready  in  1  execution unit accepts
- issue_valid  out  1  selected entry ready
- issue_payload  out  PAYLOAD_W; issue_rd_tag  out  TAG_W; issue_rs1_data / issue_rs2_data  out  32
- queue_full  out  1; queue_empty  out  1; queue_count  out  $clog2(DEPTH+1)

## Operation
- Entry fields: valid, payload, rd_tag, per operand {pending, tag, data}. Entry 0 is oldest; valid entries are contiguous from 0.
- Dispatch: when dispatch_en && !queue_full && !flush, write at index queue_count (after compaction if issuing same cycle). dispatch_en while full is ignored, no state change.
- Dispatch bypass: if an operand arrives pending and cdb_valid && cdb_tag == its tag in the same cycle, store cdb_data, pending=0.
- Wakeup: every valid pending operand with matching cdb_tag while cdb_valid captures cdb_data and clears pending at the edge. Multiple entries may wake on one broadcast.
- Ready = valid && !rs1_pending && !rs2_pending.
- Selection: lowest-index ready entry (see Configuration). issue_* outputs are combinational from the selected entry; all zero when issue_valid=0.
- Issue: on issue_valid && issue_ready, selected entry removed; entries above shift down one index, preserving age order.
- Simultaneous issue + dispatch: count unchanged; new entry lands at queue_count-1. A CDB wakeup in the same cycle applies to shifted entries.
- Flush: clears all valid bits and count; priority over dispatch, issue and wakeup; issue_valid forced 0 during the flush cycle.
- queue_full = (count == DEPTH); queue_empty = (count == 0); both from registered count.

## Timing
- Reset: all valid=0, count=0, queue_empty=1, queue_full=0, issue_valid=0, issue_* data outputs 0.
- Dispatch with ready operands: issue_valid earliest the cycle after dispatch_en (1-cycle latency).
- CDB wakeup: broadcast in cycle N, entry issuable in N+1.
- Full dispatch path is not combinationally dependent on issue_ready: full while issuing still blocks dispatch that cycle.
- No combinational path from issue_ready to issue_valid.

## Configuration
- OOO_ISSUE_EN defined: selection scans all entries, oldest ready entry issues even if older entries are pending.
- OOO_ISSUE_EN undefined: only entry 0 may issue; issue_valid = entry 0 ready. Younger ready entries wait (strict in-order, required for load/store queue).

## Test plan
- Reset mid-operation with 3 entries: assert i_rst_n=0 -> count=0, queue_empty=1, issue_valid=0 immediately, no stale issue after release.
- Dispatch ready op (rs1=5, rs2=7, rd_tag=3), issue_ready=1 -> next cycle issue_valid=1, rs1=5, rs2=7, rd_tag=3; queue empty after.
- Dispatch rs1 pending tag 9; CDB broadcasts tag 9 data 0xDEAD two cycles later -> issue_valid rises the following cycle with rs1=0xDEAD; dispatch with same-cycle tag 9 broadcast -> bypassed, issuable next cycle.
- Fill DEPTH=4 with issue_ready=0 -> queue_full=1, 5th dispatch_en ignored, count stays 4; issue one + dispatch same cycle -> count stays 4, order preserved.
- Entry0 pending tag 2, entry1 ready: with OOO_ISSUE_EN entry1 issues first; without, nothing issues until tag 2 broadcast, then entry0 then entry1.
- Flush with 3 entries and pending CDB match -> count=0 next cycle, no issue, wakeup discarded.

Source files
------------

// File: rtl/exec_issue_queue.sv
// Age-ordered issue queue between dispatch and one execution unit; operands snoop the CDB.
// Latency: an entry dispatched with ready operands is issuable the next cycle; CDB wakeup also takes one cycle.
// Backpressure: dispatch is dropped while queue_full (registered); entries hold until issue_ready accepts them.
// Build option: define OOO_ISSUE_EN to let the oldest ready entry issue past older pending ones.
module exec_issue_queue #(
    parameter int DEPTH     = 4,
    parameter int PAYLOAD_W = 64,
    parameter int TAG_W     = 6
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         flush,
    input  logic                         dispatch_en,
    input  logic [PAYLOAD_W-1:0]         dispatch_payload,
    input  logic [TAG_W-1:0]             dispatch_rd_tag,
    input  logic                         dispatch_rs1_pending,
    input  logic [TAG_W-1:0]             dispatch_rs1_tag,
    input  logic [31:0]                  dispatch_rs1_data,
    input  logic                         dispatch_rs2_pending,
    input  logic [TAG_W-1:0]             dispatch_rs2_tag,
    input  logic [31:0]                  dispatch_rs2_data,
    input  logic                         cdb_valid,
    input  logic [TAG_W-1:0]             cdb_tag,
    input  logic [31:0]                  cdb_data,
    input  logic                         issue_ready,
    output logic                         issue_valid,
    output logic [PAYLOAD_W-1:0]         issue_payload,
    output logic [TAG_W-1:0]             issue_rd_tag,
    output logic [31:0]                  issue_rs1_data,
    output logic [31:0]                  issue_rs2_data,
    output logic                         queue_full,
    output logic                         queue_empty,
    output logic [$clog2(DEPTH+1)-1:0]   queue_count
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Entry storage; index 0 is always the oldest valid entry.
    logic                 valid_q    [DEPTH];
    logic [PAYLOAD_W-1:0] payload_q  [DEPTH];
    logic [TAG_W-1:0]     rd_tag_q   [DEPTH];
    logic                 rs1_pend_q [DEPTH];
    logic [TAG_W-1:0]     rs1_tag_q  [DEPTH];
    logic [31:0]          rs1_data_q [DEPTH];
    logic                 rs2_pend_q [DEPTH];
    logic [TAG_W-1:0]     rs2_tag_q  [DEPTH];
    logic [31:0]          rs2_data_q [DEPTH];
    logic [CNT_W-1:0]     count_q;

    logic                 valid_d    [DEPTH];
    logic [PAYLOAD_W-1:0] payload_d  [DEPTH];
    logic [TAG_W-1:0]     rd_tag_d   [DEPTH];
    logic                 rs1_pend_d [DEPTH];
    logic [TAG_W-1:0]     rs1_tag_d  [DEPTH];
    logic [31:0]          rs1_data_d [DEPTH];
    logic                 rs2_pend_d [DEPTH];
    logic [TAG_W-1:0]     rs2_tag_d  [DEPTH];
    logic [31:0]          rs2_data_d [DEPTH];
    logic [CNT_W-1:0]     count_d;

    logic                 ready      [DEPTH];
    logic                 sel_found;
    logic [IDX_W-1:0]     sel_idx;
    logic                 do_issue;
    logic                 do_dispatch;
    logic [CNT_W-1:0]     wr_idx;

    assign queue_count = count_q;
    assign queue_full  = (count_q == CNT_W'(DEPTH));
    assign queue_empty = (count_q == '0);

    // Per-entry readiness and selection of the entry to present to the unit.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ready[i] = valid_q[i] && !rs1_pend_q[i] && !rs2_pend_q[i];
        end
`ifdef OOO_ISSUE_EN
        // Scan from the youngest down so the oldest ready entry wins.
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ready[i]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
`else
        // Strict in-order: only the head may leave.
        sel_found = ready[0];
        sel_idx   = '0;
`endif
    end

    // issue_valid depends only on state and flush, never on issue_ready.
    assign issue_valid    = sel_found && !flush;
    assign issue_payload  = issue_valid ? payload_q[sel_idx]  : '0;
    assign issue_rd_tag   = issue_valid ? rd_tag_q[sel_idx]   : '0;
    assign issue_rs1_data = issue_valid ? rs1_data_q[sel_idx] : '0;
    assign issue_rs2_data = issue_valid ? rs2_data_q[sel_idx] : '0;

    // Full is taken from the registered count, so an issue in the same cycle cannot open a slot.
    assign do_issue    = issue_valid && issue_ready;
    assign do_dispatch = dispatch_en && !queue_full && !flush;
    assign wr_idx      = do_issue ? (count_q - CNT_W'(1)) : count_q;

    // Next-state: compact on issue, apply CDB wakeup to the compacted entries, then write the new entry.
    always_comb begin
        valid_d    = valid_q;
        payload_d  = payload_q;
        rd_tag_d   = rd_tag_q;
        rs1_pend_d = rs1_pend_q;
        rs1_tag_d  = rs1_tag_q;
        rs1_data_d = rs1_data_q;
        rs2_pend_d = rs2_pend_q;
        rs2_tag_d  = rs2_tag_q;
        rs2_data_d = rs2_data_q;
        count_d    = count_q + CNT_W'(do_dispatch) - CNT_W'(do_issue);

        if (do_issue) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                if (IDX_W'(i) >= sel_idx) begin
                    valid_d[i]    = valid_q[i+1];
                    payload_d[i]  = payload_q[i+1];
                    rd_tag_d[i]   = rd_tag_q[i+1];
                    rs1_pend_d[i] = rs1_pend_q[i+1];
                    rs1_tag_d[i]  = rs1_tag_q[i+1];
                    rs1_data_d[i] = rs1_data_q[i+1];
                    rs2_pend_d[i] = rs2_pend_q[i+1];
                    rs2_tag_d[i]  = rs2_tag_q[i+1];
                    rs2_data_d[i] = rs2_data_q[i+1];
                end
            end
            valid_d[DEPTH-1] = 1'b0;
        end

        if (cdb_valid) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (valid_d[i] && rs1_pend_d[i] && (rs1_tag_d[i] == cdb_tag)) begin
                    rs1_pend_d[i] = 1'b0;
                    rs1_data_d[i] = cdb_data;
                end
                if (valid_d[i] && rs2_pend_d[i] && (rs2_tag_d[i] == cdb_tag)) begin
                    rs2_pend_d[i] = 1'b0;
                    rs2_data_d[i] = cdb_data;
                end
            end
        end

        if (do_dispatch) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (CNT_W'(i) == wr_idx) begin
                    valid_d[i]    = 1'b1;
                    payload_d[i]  = dispatch_payload;
                    rd_tag_d[i]   = dispatch_rd_tag;
                    rs1_tag_d[i]  = dispatch_rs1_tag;
                    rs2_tag_d[i]  = dispatch_rs2_tag;
                    // A broadcast of the producer in the dispatch cycle is captured directly.
                    if (dispatch_rs1_pending && !(cdb_valid && (cdb_tag == dispatch_rs1_tag))) begin
                        rs1_pend_d[i] = 1'b1;
                        rs1_data_d[i] = dispatch_rs1_data;
                    end else begin
                        rs1_pend_d[i] = 1'b0;
                        rs1_data_d[i] = dispatch_rs1_pending ? cdb_data : dispatch_rs1_data;
                    end
                    if (dispatch_rs2_pending && !(cdb_valid && (cdb_tag == dispatch_rs2_tag))) begin
                        rs2_pend_d[i] = 1'b1;
                        rs2_data_d[i] = dispatch_rs2_data;
                    end else begin
                        rs2_pend_d[i] = 1'b0;
                        rs2_data_d[i] = dispatch_rs2_pending ? cdb_data : dispatch_rs2_data;
                    end
                end
            end
        end

        // Flush wins over everything else; payload fields are left as don't-care.
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_d[i] = 1'b0;
            end
            count_d = '0;
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i]    <= 1'b0;
                payload_q[i]  <= '0;
                rd_tag_q[i]   <= '0;
                rs1_pend_q[i] <= 1'b0;
                rs1_tag_q[i]  <= '0;
                rs1_data_q[i] <= '0;
                rs2_pend_q[i] <= 1'b0;
                rs2_tag_q[i]  <= '0;
                rs2_data_q[i] <= '0;
            end
            count_q <= '0;
        end else begin
            valid_q    <= valid_d;
            payload_q  <= payload_d;
            rd_tag_q   <= rd_tag_d;
            rs1_pend_q <= rs1_pend_d;
            rs1_tag_q  <= rs1_tag_d;
            rs1_data_q <= rs1_data_d;
            rs2_pend_q <= rs2_pend_d;
            rs2_tag_q  <= rs2_tag_d;
            rs2_data_q <= rs2_data_d;
            count_q    <= count_d;
        end
    end

endmodule

// File: tb/tb_exec_issue_queue.sv
// Directed bench for exec_issue_queue (DEPTH=4): dispatch, wakeup, bypass, full, ordering, flush, reset.
// Inputs change 1ns after the rising edge; outputs are sampled at that same point.
// Expectations follow the in-order build unless OOO_ISSUE_EN is defined.
module tb_exec_issue_queue;

    localparam int DEPTH = 4;
    localparam int PW    = 64;
    localparam int TW    = 6;

    logic          i_clk;
    logic          i_rst_n;
    logic          flush;
    logic          dispatch_en;
    logic [PW-1:0] dispatch_payload;
    logic [TW-1:0] dispatch_rd_tag;
    logic          dispatch_rs1_pending;
    logic [TW-1:0] dispatch_rs1_tag;
    logic [31:0]   dispatch_rs1_data;
    logic          dispatch_rs2_pending;
    logic [TW-1:0] dispatch_rs2_tag;
    logic [31:0]   dispatch_rs2_data;
    logic          cdb_valid;
    logic [TW-1:0] cdb_tag;
    logic [31:0]   cdb_data;
    logic          issue_ready;
    logic          issue_valid;
    logic [PW-1:0] issue_payload;
    logic [TW-1:0] issue_rd_tag;
    logic [31:0]   issue_rs1_data;
    logic [31:0]   issue_rs2_data;
    logic          queue_full;
    logic          queue_empty;
    logic [2:0]    queue_count;

    int total = 0;
    int bad   = 0;

    exec_issue_queue #(.DEPTH(DEPTH), .PAYLOAD_W(PW), .TAG_W(TW)) dut (
        .i_clk                (i_clk),
        .i_rst_n              (i_rst_n),
        .flush                (flush),
        .dispatch_en          (dispatch_en),
        .dispatch_payload     (dispatch_payload),
        .dispatch_rd_tag      (dispatch_rd_tag),
        .dispatch_rs1_pending (dispatch_rs1_pending),
        .dispatch_rs1_tag     (dispatch_rs1_tag),
        .dispatch_rs1_data    (dispatch_rs1_data),
        .dispatch_rs2_pending (dispatch_rs2_pending),
        .dispatch_rs2_tag     (dispatch_rs2_tag),
        .dispatch_rs2_data    (dispatch_rs2_data),
        .cdb_valid            (cdb_valid),
        .cdb_tag              (cdb_tag),
        .cdb_data             (cdb_data),
        .issue_ready          (issue_ready),
        .issue_valid          (issue_valid),
        .issue_payload        (issue_payload),
        .issue_rd_tag         (issue_rd_tag),
        .issue_rs1_data       (issue_rs1_data),
        .issue_rs2_data       (issue_rs2_data),
        .queue_full           (queue_full),
        .queue_empty          (queue_empty),
        .queue_count          (queue_count)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle;
        dispatch_en = 1'b0;
        cdb_valid   = 1'b0;
        flush       = 1'b0;
    endtask

    task automatic disp(input logic [63:0] pl, input logic [5:0] rd,
                        input logic p1, input logic [5:0] t1, input logic [31:0] d1,
                        input logic p2, input logic [5:0] t2, input logic [31:0] d2);
        dispatch_en          = 1'b1;
        dispatch_payload     = pl;
        dispatch_rd_tag      = rd;
        dispatch_rs1_pending = p1;
        dispatch_rs1_tag     = t1;
        dispatch_rs1_data    = d1;
        dispatch_rs2_pending = p2;
        dispatch_rs2_tag     = t2;
        dispatch_rs2_data    = d2;
    endtask

    task automatic cdb(input logic [5:0] t, input logic [31:0] d);
        cdb_valid = 1'b1;
        cdb_tag   = t;
        cdb_data  = d;
    endtask

    initial begin
        i_rst_n = 1'b0;
        issue_ready = 1'b0;
        cdb_tag = '0;
        cdb_data = '0;
        idle();
        disp(64'h0, 6'd0, 1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 32'd0);
        dispatch_en = 1'b0;
        tick();
        tick();
        chk("rst_count", queue_count, 0);
        chk("rst_empty", queue_empty, 1);
        chk("rst_full", queue_full, 0);
        chk("rst_issue_valid", issue_valid, 0);
        chk("rst_payload", issue_payload, 0);
        chk("rst_rs1", issue_rs1_data, 0);
        i_rst_n = 1'b1;
        tick();

        // Ready operands: issuable exactly one cycle after dispatch.
        issue_ready = 1'b1;
        disp(64'h111, 6'd3, 1'b0, 6'd0, 32'd5, 1'b0, 6'd0, 32'd7);
        chk("disp_same_cycle_valid", issue_valid, 0);
        tick();
        idle();
        chk("ready_valid", issue_valid, 1);
        chk("ready_rs1", issue_rs1_data, 5);
        chk("ready_rs2", issue_rs2_data, 7);
        chk("ready_rd", issue_rd_tag, 3);
        chk("ready_payload", issue_payload, 64'h111);
        tick();
        chk("ready_drained", queue_empty, 1);
        chk("ready_valid_after", issue_valid, 0);

        // Pending rs1 on tag 9; an unrelated tag must not wake it.
        disp(64'h222, 6'd4, 1'b1, 6'd9, 32'd0, 1'b0, 6'd0, 32'd1);
        tick();
        idle();
        cdb(6'd8, 32'h5555);
        chk("pend_valid0", issue_valid, 0);
        tick();
        idle();
        cdb(6'd9, 32'hDEAD);
        chk("pend_wrong_tag", issue_valid, 0);
        tick();
        idle();
        chk("wake_valid", issue_valid, 1);
        chk("wake_rs1", issue_rs1_data, 32'hDEAD);
        chk("wake_rs2", issue_rs2_data, 1);
        chk("wake_rd", issue_rd_tag, 4);
        tick();
        chk("wake_drained", queue_count, 0);

        // Producer broadcast in the dispatch cycle is bypassed into the entry.
        disp(64'h333, 6'd5, 1'b1, 6'd9, 32'd0, 1'b0, 6'd0, 32'd2);
        cdb(6'd9, 32'hBEEF);
        tick();
        idle();
        chk("bypass_valid", issue_valid, 1);
        chk("bypass_rs1", issue_rs1_data, 32'hBEEF);
        tick();
        chk("bypass_drained", queue_empty, 1);

        // Fill to DEPTH with the unit stalled.
        issue_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            disp(64'hA0 + 64'(i), 6'(10 + i), 1'b0, 6'd0, 32'(i), 1'b0, 6'd0, 32'(100 + i));
            tick();
        end
        idle();
        chk("fill_count", queue_count, 4);
        chk("fill_full", queue_full, 1);
        chk("fill_empty", queue_empty, 0);
        chk("fill_head", issue_payload, 64'hA0);
        disp(64'hA4, 6'd14, 1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 32'd0);
        tick();
        idle();
        chk("full_drop_count", queue_count, 4);
        chk("full_drop_head", issue_payload, 64'hA0);
        // Full while issuing still refuses the dispatch.
        issue_ready = 1'b1;
        disp(64'hA5, 6'd15, 1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 32'd0);
        tick();
        idle();
        chk("full_issue_count", queue_count, 3);
        chk("full_issue_head", issue_payload, 64'hA1);
        // Issue and dispatch together below full: count holds, new entry goes to the tail.
        disp(64'hA6, 6'd16, 1'b0, 6'd0, 32'd6, 1'b0, 6'd0, 32'd0);
        tick();
        idle();
        chk("swap_count", queue_count, 3);
        issue_ready = 1'b0;
        disp(64'hA7, 6'd17, 1'b0, 6'd0, 32'd7, 1'b0, 6'd0, 32'd0);
        tick();
        idle();
        chk("refill_count", queue_count, 4);
        issue_ready = 1'b1;
        chk("order0", issue_payload, 64'hA2);
        tick();
        chk("order1", issue_payload, 64'hA3);
        tick();
        chk("order2", issue_payload, 64'hA6);
        chk("order2_rd", issue_rd_tag, 16);
        tick();
        chk("order3", issue_payload, 64'hA7);
        tick();
        chk("order_drained", queue_empty, 1);

        // Head pending on tag 2, younger entry ready.
        issue_ready = 1'b0;
        disp(64'hC0, 6'd20, 1'b1, 6'd2, 32'd0, 1'b0, 6'd0, 32'd3);
        tick();
        disp(64'hC1, 6'd21, 1'b0, 6'd0, 32'd4, 1'b0, 6'd0, 32'd5);
        tick();
        idle();
        issue_ready = 1'b1;
`ifdef OOO_ISSUE_EN
        chk("ooo_first_valid", issue_valid, 1);
        chk("ooo_first", issue_payload, 64'hC1);
        tick();
        chk("ooo_count", queue_count, 1);
        chk("ooo_wait", issue_valid, 0);
`else
        chk("ino_blocked", issue_valid, 0);
        tick();
        chk("ino_count", queue_count, 2);
        chk("ino_still_blocked", issue_valid, 0);
`endif
        cdb(6'd2, 32'h22);
        tick();
        idle();
        chk("dep_head_valid", issue_valid, 1);
        chk("dep_head", issue_payload, 64'hC0);
        chk("dep_head_rs1", issue_rs1_data, 32'h22);
        tick();
`ifndef OOO_ISSUE_EN
        chk("ino_second", issue_payload, 64'hC1);
        tick();
`endif
        chk("dep_drained", queue_empty, 1);

        // Flush with a matching broadcast and a dispatch in the same cycle.
        issue_ready = 1'b0;
        disp(64'hD0, 6'd30, 1'b1, 6'd7, 32'd0, 1'b0, 6'd0, 32'd0);
        tick();
        disp(64'hD1, 6'd31, 1'b0, 6'd0, 32'd1, 1'b0, 6'd0, 32'd0);
        tick();
        disp(64'hD2, 6'd32, 1'b0, 6'd0, 32'd2, 1'b0, 6'd0, 32'd0);
        tick();
        idle();
        chk("pre_flush_count", queue_count, 3);
        issue_ready = 1'b1;
        flush = 1'b1;
        cdb(6'd7, 32'h77);
        disp(64'hF0, 6'd33, 1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 32'd0);
        chk("flush_cycle_valid", issue_valid, 0);
        tick();
        idle();
        chk("flush_count", queue_count, 0);
        chk("flush_empty", queue_empty, 1);
        chk("flush_valid", issue_valid, 0);
        tick();
        chk("flush_no_stale", issue_valid, 0);
        disp(64'hE0, 6'd34, 1'b0, 6'd0, 32'd9, 1'b0, 6'd0, 32'd0);
        tick();
        idle();
        chk("post_flush_payload", issue_payload, 64'hE0);
        tick();

        // Asynchronous reset in the middle of a cycle with three entries queued.
        issue_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            disp(64'hB0 + 64'(i), 6'(40 + i), 1'b0, 6'd0, 32'(i), 1'b0, 6'd0, 32'd0);
            tick();
        end
        idle();
        chk("prereset_count", queue_count, 3);
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("arst_count", queue_count, 0);
        chk("arst_empty", queue_empty, 1);
        chk("arst_valid", issue_valid, 0);
        chk("arst_payload", issue_payload, 0);
        tick();
        i_rst_n = 1'b1;
        issue_ready = 1'b1;
        tick();
        chk("arst_no_stale", issue_valid, 0);
        chk("arst_count_after", queue_count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
